if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the decode stage and produces the PC/instruction pair that decode registers.
- Owns the PC register and next-PC selection: sequential, branch redirect from execute, jump redirect from decode.
- Drives a valid/ack instruction-memory handshake.
- Holds its output stable under decode pause, using a one-entry skid buffer.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0000, instruction word presented when the output slot is empty or flushed

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
i_pause  in  1  decode stall request; output slot must hold
i_brTaken  in  1  branch resolved taken (from execute)
i_brTarget  in  32  branch target address
i_jump  in  1  jump decoded (from decode)
i_jumpLow  in  26  jump target field (inst[25:0])
i_jumpBase  in  32  PC+4 of the jump instruction
o_imem_req  out  1  fetch request valid
o_imem_addr  out  32  fetch address, word aligned
i_imem_ack  in  1  memory returns data this cycle
i_imem_rdata  in  32  instruction word
o_IF_PC  out  32  fetch address + 4 of presented instruction
o_IF_inst  out  32  presented instruction
o_IF_valid  out  1  presented instruction is real (not a bubble)

Behaviour:
- Reset (async, immediate):
  - pc_q=RESET_PC, state=S_REQ.
  - o_imem_req=0 while rstn low; o_imem_req=1 from the first clk edge after release.
  - o_IF_PC=RESET_PC, o_IF_inst=NOP_INST, o_IF_valid=0, skid empty.
- Redirect: redir = i_brTaken | i_jump.
  - Target = i_brTarget if i_brTaken, else {i_jumpBase[31:28], i_jumpLow, 2'b00}.
  - Branch wins when both are asserted, because the branch belongs to the older instruction.
  - No delay slot. On redir the output slot is flushed next edge (o_IF_inst=NOP_INST, o_IF_valid=0) regardless of i_pause.
- Handshake:
  - o_imem_addr=pc_q.
  - Address and req stay stable from req rise until the ack cycle.
  - Data is consumed only in a cycle with req & ack.
  - Zero-wait memory (ack every cycle) yields 1 instruction/cycle.
- FSM states:
  - S_REQ (req=1):
    - ack & redir: discard data; pc_q<=target; stay.
    - ack & !pause: output slot <= {pc_q+4, rdata, valid=1}; pc_q<=pc_q+4; stay.
    - ack & pause & slot valid: skid <= {pc_q+4, rdata}; pc_q<=pc_q+4; go S_HOLD.
    - ack & pause & slot empty: load the slot directly, as in the !pause case.
    - !ack & redir: pend<=target; go S_DROP.
    - !ack otherwise: wait, with the output slot unchanged.
  - S_DROP (req=1, same old address):
    - Later redir overwrites pend (latest wins).
    - On ack: discard data; pc_q<=pend, or the current target if redir is asserted in the ack cycle; go S_REQ.
  - S_HOLD (req=0):
    - redir: clear skid; pc_q<=target; go S_REQ.
    - !pause: slot<=skid; skid empty; go S_REQ.
    - pause: hold.
- Pause without redir never changes o_IF_PC/o_IF_inst/o_IF_valid.
- The slot empties to a bubble only by flush.
- PC arithmetic is 32-bit and wraps modulo 2^32: pc_q=32'hFFFF_FFFC advances to 0.
- Reset asserted mid-request abandons the request. Memory must tolerate a dropped req.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds outputs o_IF_fetchCnt[31:0] and o_IF_stallCnt[31:0]:
  - fetchCnt increments when the slot loads a valid instruction.
  - stallCnt increments each cycle with req & !ack or state S_HOLD.
  - Both reset to 0 and wrap.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Shared package holds:
  - state encoding (S_REQ, S_DROP, S_HOLD);
  - NOP_INST default;
  - the PC_INC=4 constant.
- The jump-target concatenation helper function is shared with decode.
- One natural sub-module: if_skid_buf. It is the one-entry PC/inst holding register with load/pop/clear and a valid flag.

Test Plan:
1. Reset release, ack every cycle, rdata=addr-based pattern -> o_imem_addr 0,4,8,…; o_IF_PC 4,8,12 one cycle behind; o_IF_valid=1 from the 2nd edge.
2. i_pause high for 3 cycles during steady fetch with ack -> output frozen at the same PC. One extra word is taken into skid and req drops. After release the skid word appears next with no loss or duplication.
3. i_brTaken=1, i_brTarget=32'h100, with i_jump=1 in the same cycle -> next addr 32'h100. Slot shows NOP with valid=0 for one cycle, then PC 32'h104.
4. i_jump=1, i_jumpBase=32'hA000_0010, i_jumpLow=26'h40 while ack is delayed 3 cycles -> address held until ack, data discarded, next fetch at 32'hA000_0100.
5. pc_q=32'hFFFF_FFFC, ack -> next addr 32'h0000_0000; o_IF_PC=0.
6. rstn pulsed low mid-S_HOLD -> outputs immediately return to their reset values; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its decode-side neighbours.
package if_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned JLOW_W = 26;

    localparam logic [XLEN-1:0] PC_INC           = XLEN'(4);
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = XLEN'(0);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DROP = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

    // J-type target: top nibble of PC+4, 26-bit word index, word alignment.
    function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0]   base,
                                                    input logic [JLOW_W-1:0] low);
        return {base[XLEN-1:XLEN-4], low, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory valid/ack fetch port between the fetch stage and memory.
interface if_stage_if;
    import if_stage_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry PC/instruction holding register used while decode is paused.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic       pop,
    input  logic       clear,
    input  fetch_pkt_t d,
    output fetch_pkt_t q,
    output logic       valid
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear || pop) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC/next-PC selection, imem valid/ack fetch, pause skid buffer.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(0),
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_pause,
    input  logic              i_brTaken,
    input  logic [XLEN-1:0]   i_brTarget,
    input  logic              i_jump,
    input  logic [JLOW_W-1:0] i_jumpLow,
    input  logic [XLEN-1:0]   i_jumpBase,
    if_stage_if.master        imem,
    output logic [XLEN-1:0]   o_IF_PC,
    output logic [XLEN-1:0]   o_IF_inst,
    output logic              o_IF_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       o_IF_fetchCnt,
    output logic [31:0]       o_IF_stallCnt
`endif
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            req_q, req_d;
    fetch_pkt_t      slot_q, slot_d;
    logic            slot_valid_q, slot_valid_d;

    logic            redir, fire, slot_load;
    logic [XLEN-1:0] target, pc_inc;
    logic            skid_load, skid_pop, skid_clear, skid_valid;
    fetch_pkt_t      skid_q;

    if_skid_buf u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .load  (skid_load),
        .pop   (skid_pop),
        .clear (skid_clear),
        .d     ({pc_inc, imem.imem_rdata}),
        .q     (skid_q),
        .valid (skid_valid)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign o_IF_PC        = slot_q.pc;
    assign o_IF_inst      = slot_q.inst;
    assign o_IF_valid     = slot_valid_q;

    // Next-state, next-PC and output-slot selection.
    always_comb begin
        redir        = i_brTaken | i_jump;
        target       = i_brTaken ? i_brTarget : jump_target(i_jumpBase, i_jumpLow);
        fire         = req_q & imem.imem_ack;
        pc_inc       = pc_q + PC_INC;
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        slot_load    = 1'b0;
        skid_load    = 1'b0;
        skid_pop     = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (fire) begin
                    if (redir) begin
                        pc_d = target;
                    end else if (!i_pause || !slot_valid_q) begin
                        slot_load = 1'b1;
                        slot_d    = '{pc: pc_inc, inst: imem.imem_rdata};
                        pc_d      = pc_inc;
                    end else begin
                        skid_load = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = S_HOLD;
                    end
                end else if (redir) begin
                    // Before req has risen the address may still move freely.
                    if (req_q) begin
                        pend_d  = target;
                        state_d = S_DROP;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            S_DROP: begin
                if (redir) pend_d = target;
                if (fire) begin
                    pc_d    = redir ? target : pend_q;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    skid_clear = 1'b1;
                    pc_d       = target;
                    state_d    = S_REQ;
                end else if (!i_pause && skid_valid) begin
                    skid_pop  = 1'b1;
                    slot_load = 1'b1;
                    slot_d    = skid_q;
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (slot_load) slot_valid_d = 1'b1;
        if (redir) begin
            slot_valid_d = 1'b0;
            slot_d.inst  = NOP_INST;
        end
        req_d = (state_d != S_HOLD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pend_q       <= RESET_PC;
            req_q        <= 1'b0;
            slot_q       <= '{pc: RESET_PC, inst: NOP_INST};
            slot_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            req_q        <= req_d;
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Loaded instructions, and cycles spent waiting on memory or held by decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_IF_fetchCnt <= 32'd0;
            o_IF_stallCnt <= 32'd0;
        end else begin
            o_IF_fetchCnt <= o_IF_fetchCnt + 32'(slot_load);
            o_IF_stallCnt <= o_IF_stallCnt +
                             32'((req_q & ~imem.imem_ack) | (state_q == S_HOLD));
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a queue-based fetch model.
module tb_if_stage;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] T_NOP      = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } word_t;

    logic        clk, rstn;
    logic        pause, br, jmp, ack;
    logic [31:0] br_tgt, jbase;
    logic [25:0] jlow;
    logic [31:0] dut_pc, dut_inst;
    logic        dut_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] dut_fcnt, dut_scnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [31:0] m_addr;
    bit          m_started, m_doomed;
    logic [31:0] m_redirect_to;
    word_t       skid[$];
    word_t       m_slot;
    bit          m_valid;
    logic [31:0] m_fetch, m_stall;

    if_stage_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    assign bus.imem_ack   = ack;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    if_stage #(.RESET_PC(T_RESET_PC), .NOP_INST(T_NOP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_pause    (pause),
        .i_brTaken  (br),
        .i_brTarget (br_tgt),
        .i_jump     (jmp),
        .i_jumpLow  (jlow),
        .i_jumpBase (jbase),
        .imem       (bus),
        .o_IF_PC    (dut_pc),
        .o_IF_inst  (dut_inst),
        .o_IF_valid (dut_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .o_IF_fetchCnt (dut_fcnt),
        .o_IF_stallCnt (dut_scnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_addr    = T_RESET_PC;
        m_started = 0;
        m_doomed  = 0;
        skid.delete();
        m_slot    = '{pc: T_RESET_PC, inst: T_NOP};
        m_valid   = 0;
        m_fetch   = 0;
        m_stall   = 0;
    endtask

    // One clock of fetch behaviour: req is up whenever nothing is parked for decode.
    task automatic model_step();
        bit          redir, holding, req;
        logic [31:0] tgt;
        if (!rstn) return;
        redir   = br || jmp;
        tgt     = br ? br_tgt : {jbase[31:28], jlow, 2'b00};
        holding = skid.size() != 0;
        req     = m_started && !holding;
        if ((req && !ack) || holding) m_stall = m_stall + 1;
        if (holding) begin
            if (redir) begin
                skid.delete();
                m_addr = tgt;
            end else if (!pause) begin
                m_slot  = skid.pop_front();
                m_valid = 1;
                m_fetch = m_fetch + 1;
            end
        end else if (req && ack) begin
            if (redir) m_addr = tgt;
            else if (m_doomed) m_addr = m_redirect_to;
            else if (pause && m_valid) begin
                skid.push_back('{pc: m_addr + 32'd4, inst: mem_word(m_addr)});
                m_addr = m_addr + 32'd4;
            end else begin
                m_slot  = '{pc: m_addr + 32'd4, inst: mem_word(m_addr)};
                m_valid = 1;
                m_fetch = m_fetch + 1;
                m_addr  = m_addr + 32'd4;
            end
            m_doomed = 0;
        end else if (redir) begin
            if (req) begin
                m_doomed      = 1;
                m_redirect_to = tgt;
            end else begin
                m_addr = tgt;
            end
        end
        if (redir) begin
            m_valid     = 0;
            m_slot.inst = T_NOP;
        end
        m_started = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        chk("imem_req",   32'(bus.imem_req), 32'(m_started && skid.size() == 0 && rstn));
        chk("imem_addr",  bus.imem_addr, m_addr);
        chk("IF_PC",      dut_pc, m_slot.pc);
        chk("IF_inst",    dut_inst, m_slot.inst);
        chk("IF_valid",   32'(dut_valid), 32'(m_valid));
`ifdef IF_PERF_CNT_EN
        chk("fetchCnt",   dut_fcnt, m_fetch);
        chk("stallCnt",   dut_scnt, m_stall);
`endif
    end

    initial begin
        rstn = 0; pause = 0; br = 0; jmp = 0; ack = 1;
        br_tgt = 0; jbase = 0; jlow = 0;
        model_reset();
        tick();
        tick();
        rstn = 1;

        // Sequential fetch with zero-wait memory.
        tick();
        chk("t1_addr0", bus.imem_addr, 32'h0);
        chk("t1_req", 32'(bus.imem_req), 32'd1);
        chk("t1_valid0", 32'(dut_valid), 32'd0);
        tick();
        chk("t1_valid1", 32'(dut_valid), 32'd1);
        chk("t1_pc4", dut_pc, 32'h4);
        chk("t1_addr4", bus.imem_addr, 32'h4);
        tick();
        chk("t1_pc8", dut_pc, 32'h8);
        chk("t1_inst", dut_inst, 32'h1234_567C);

        // Three-cycle decode pause: one word parks in the skid buffer.
        pause = 1;
        tick();
        chk("t2_req_drop", 32'(bus.imem_req), 32'd0);
        chk("t2_pc_frozen", dut_pc, 32'h8);
        tick();
        tick();
        chk("t2_pc_still", dut_pc, 32'h8);
        pause = 0;
        tick();
        chk("t2_skid_pc", dut_pc, 32'hC);
        chk("t2_skid_inst", dut_inst, 32'h1234_5670);
        tick();
        chk("t2_next_pc", dut_pc, 32'h10);

        // Branch and jump together: branch wins.
        br = 1; br_tgt = 32'h100; jmp = 1; jbase = 32'h5000_0000; jlow = 26'h123;
        tick();
        br = 0; jmp = 0;
        chk("t3_addr", bus.imem_addr, 32'h100);
        chk("t3_flush_valid", 32'(dut_valid), 32'd0);
        chk("t3_flush_inst", dut_inst, T_NOP);
        tick();
        chk("t3_pc", dut_pc, 32'h104);

        // Jump while memory stalls: old address held, returned data dropped.
        jmp = 1; jbase = 32'hA000_0010; jlow = 26'h40; ack = 0;
        tick();
        jmp = 0;
        tick();
        chk("t4_addr_held", bus.imem_addr, 32'h104);
        chk("t4_req_held", 32'(bus.imem_req), 32'd1);
        tick();
        ack = 1;
        tick();
        chk("t4_addr_jump", bus.imem_addr, 32'hA000_0100);
        chk("t4_dropped", 32'(dut_valid), 32'd0);
        tick();
        chk("t4_pc", dut_pc, 32'hA000_0104);

        // PC wrap at the top of the address space.
        br = 1; br_tgt = 32'hFFFF_FFFC;
        tick();
        br = 0;
        chk("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_addr_wrap", bus.imem_addr, 32'h0);
        chk("t5_pc_wrap", dut_pc, 32'h0);

        // Reset asserted while holding.
        pause = 1;
        tick();
        chk("t6_hold", 32'(bus.imem_req), 32'd0);
        tick();
        rstn = 0;
        model_reset();
        #1;
        chk("t6_rst_req", 32'(bus.imem_req), 32'd0);
        chk("t6_rst_addr", bus.imem_addr, T_RESET_PC);
        chk("t6_rst_pc", dut_pc, T_RESET_PC);
        chk("t6_rst_inst", dut_inst, T_NOP);
        chk("t6_rst_valid", 32'(dut_valid), 32'd0);
        pause = 0;
        tick();
        rstn = 1;
        tick();
        chk("t6_resume", bus.imem_addr, T_RESET_PC);
        tick();
        chk("t6_resume_pc", dut_pc, 32'h4);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            pause  = ($urandom_range(0, 99) < 30);
            br     = ($urandom_range(0, 99) < 8);
            jmp    = ($urandom_range(0, 99) < 8);
            ack    = ($urandom_range(0, 99) < 70);
            br_tgt = $urandom() & 32'hFFFF_FFFC;
            jbase  = $urandom();
            jlow   = 26'($urandom());
            if (i % 997 == 500) begin
                rstn = 0;
                model_reset();
                tick();
                rstn = 1;
            end
            tick();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
